common_pseudo_lru_tree_binwr_sets: RTL and testbench
====================================================

Name: common_pseudo_lru_tree_binwr_sets

Overview:
Multi-set tree pseudo-LRU replacement engine with an encoded binary way interface. It is the set-associative successor of the single-group binary-write PLRU. It keeps one (WAYS-1)-bit PLRU tree per set, takes way "touches" (hits or fills), and answers registered victim queries per set. Victim queries honour an invalid-way mask and can optionally allocate, i.e. mark the returned victim as MRU. It sits beside the tag arrays of caches and TLBs.

Parameters:
SET_COUNT_LOG2, 2, log2 of number of sets; ≥0 (0 means a single set).
WAY_COUNT_LOG2, 2, log2 of ways per set; ≥1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wen  in  1  touch request
wset  in  SET_COUNT_LOG2 (min 1)  set index of touch
waddr  in  WAY_COUNT_LOG2  way touched; becomes MRU
qen  in  1  victim query request
qset  in  SET_COUNT_LOG2 (min 1)  set index of query
qvalid_mask  in  2^WAY_COUNT_LOG2  per-way valid bits of queried set (bit i = way i)
qalloc  in  1  with qen: mark returned victim MRU
qresp_valid  out  1  victim response valid
qresp_addr  out  WAY_COUNT_LOG2  victim way

Behaviour:
- Decided: one clock domain (clk); reset is synchronous and active-high.
- State: SET_COUNT × (WAYS-1) tree bits in heap order.
  - Node 0 is the root. Children of node n are 2n+1 and 2n+2.
  - Leaves map to ways 0..WAYS-1 left to right.
  - Node bit 0 means the victim lies in the left (lower-index) subtree; 1 means the right subtree.
- Reset: all tree bits 0 (victim of every set = way 0); qresp_valid=0; qresp_addr=0. Reset in the cycle after a qen drops that response (qresp_valid=0 next cycle).
- Victim selection, combinational from the current state of qset:
  - If qvalid_mask is not all ones, victim = lowest-index way whose mask bit is 0.
  - Otherwise victim = leaf reached by walking from the root along the node bits.
- Query latency is 1 cycle:
  - qen in cycle N gives qresp_valid=1 and qresp_addr=victim in cycle N+1, computed from state at the start of cycle N.
  - qresp_valid is 0 in any cycle following a cycle without qen.
  - qresp_addr holds its last value when qresp_valid=0.
  - Back-to-back queries are allowed every cycle.
- Touch of way w: every node on the root-to-leaf path of w is set to point away from w (left child on path → bit 1; right child on path → bit 0). Off-path nodes are unchanged. Committed at the clock edge; visible to queries from cycle N+1.
- Alloc (qen & qalloc): the selected victim is touched exactly as above, including when it was chosen via the invalid mask.
- Simultaneous touch and alloc to the same set:
  - The victim is computed from pre-update state.
  - The next state is touch(waddr) applied first, then touch(victim); the alloc overrides shared path nodes.
- Different sets in the same cycle are updated independently.
- Query with no alloc in the same cycle as a touch to the same set: the response reflects pre-touch state (no bypass).
- qset/wset are not range-checked; all indices are valid by construction (power-of-two sizes).
- No backpressure; the block accepts every request every cycle.

Decomposition:
- Shared package: localparams WAYS=1<<WAY_COUNT_LOG2, NODES=WAYS-1, SETS=1<<SET_COUNT_LOG2.
- Shared package functions: plru_touch(tree, way), plru_victim(tree), lowest_zero(mask).
- One natural sub-module: common_pseudo_lru_tree_node_path. It is combinational: given a tree vector and a way, it returns the updated tree and the walked victim. Instantiated twice for chained touch→alloc updates and once for victim selection.
- Storage is a flat register array indexed by set.

Test Plan (WAY_COUNT_LOG2=2, SET_COUNT_LOG2=2, qvalid_mask=4'b1111 unless stated):
1. After reset, qen qset=0 → next cycle qresp_valid=1, qresp_addr=0. Idle cycle → qresp_valid=0.
2. Touch set0 way0, then query set0 → 2. Touch way2, then query → 1. Touch 0,1,2,3 in order, then query → 0.
3. Touch set1 way0 ×3, then query set0 → 0 and query set1 → 2 (set isolation).
4. Query set0 with qvalid_mask=4'b1011 after touching way2 → 2. Mask 4'b0000 → 0.
5. qen+qalloc on fresh set2 → response 0. Repeat qen+qalloc → 2, then 1, then 3.
6. Same cycle on fresh set3: wen waddr=3, and qen qalloc → response 0; the following query of set3 → 2. Assert reset in the cycle after a qen → qresp_valid=0 and set state back to victim 0.

Source files
------------

// File: rtl/common_pseudo_lru_tree_binwr_sets_pkg.sv
// Shared definitions for the multi-set binary-write tree PLRU.
// Default geometry localparams plus the tree helpers. The helpers operate on
// vectors sized for the largest supported tree (MAX_WAY_LOG2 levels). They
// take the real level count as an argument, so one set of functions serves
// every instance geometry. Only the low (ways-1) node bits and the low
// way_log2 result bits are meaningful.
package common_pseudo_lru_tree_binwr_sets_pkg;

  localparam int DEF_SET_COUNT_LOG2 = 2;
  localparam int DEF_WAY_COUNT_LOG2 = 2;
  localparam int WAYS  = 1 << DEF_WAY_COUNT_LOG2;
  localparam int NODES = WAYS - 1;
  localparam int SETS  = 1 << DEF_SET_COUNT_LOG2;

  localparam int MAX_WAY_LOG2 = 5;
  localparam int MAX_WAYS     = 1 << MAX_WAY_LOG2;
  localparam int MAX_NODES    = MAX_WAYS - 1;

  // Point every node on the root-to-leaf path of `way` away from it.
  // The way bits are consumed MSB first: a 0 bit steps left, a 1 bit steps right.
  function automatic logic [MAX_NODES-1:0] plru_touch(
    input logic [MAX_NODES-1:0]    tree,
    input logic [MAX_WAY_LOG2-1:0] way,
    input int                      wlog2
  );
    logic [MAX_NODES-1:0]    t;
    logic [MAX_WAY_LOG2-1:0] w;
    logic [MAX_WAY_LOG2-1:0] node;
    logic                    b;
    t    = tree;
    w    = way << (MAX_WAY_LOG2 - wlog2);
    node = '0;
    b    = 1'b0;
    for (int lvl = 0; lvl < MAX_WAY_LOG2; lvl++) begin
      if (lvl < wlog2) begin
        b       = w[MAX_WAY_LOG2-1];
        t[node] = ~b;
        node    = {node[MAX_WAY_LOG2-2:0], 1'b0} + MAX_WAY_LOG2'(1) + MAX_WAY_LOG2'(b);
        w       = w << 1;
      end
    end
    return t;
  endfunction

  // Follow the node bits from the root down to a leaf.
  function automatic logic [MAX_WAY_LOG2-1:0] plru_victim(
    input logic [MAX_NODES-1:0] tree,
    input int                   wlog2
  );
    logic [MAX_WAY_LOG2-1:0] v;
    logic [MAX_WAY_LOG2-1:0] node;
    logic                    b;
    v    = '0;
    node = '0;
    b    = 1'b0;
    for (int lvl = 0; lvl < MAX_WAY_LOG2; lvl++) begin
      if (lvl < wlog2) begin
        b    = tree[node];
        v    = {v[MAX_WAY_LOG2-2:0], b};
        node = {node[MAX_WAY_LOG2-2:0], 1'b0} + MAX_WAY_LOG2'(1) + MAX_WAY_LOG2'(b);
      end
    end
    return v;
  endfunction

  // Index of the lowest clear bit. Callers pad unused mask bits with ones.
  function automatic logic [MAX_WAY_LOG2-1:0] lowest_zero(input logic [MAX_WAYS-1:0] mask);
    logic [MAX_WAY_LOG2-1:0] idx;
    idx = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (!mask[i]) idx = i[MAX_WAY_LOG2-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/common_pseudo_lru_tree_node_path.sv
// Combinational PLRU tree path unit.
//   tree_in  : current (ways-1)-bit heap-ordered tree
//   way      : way to mark MRU
//   tree_out : tree_in with the path of `way` pointed away from it
//   victim   : leaf reached by walking tree_in from the root
module common_pseudo_lru_tree_node_path
  import common_pseudo_lru_tree_binwr_sets_pkg::*;
#(
  parameter int WAY_COUNT_LOG2 = 2
) (
  input  logic [(1<<WAY_COUNT_LOG2)-2:0] tree_in,
  input  logic [WAY_COUNT_LOG2-1:0]      way,
  output logic [(1<<WAY_COUNT_LOG2)-2:0] tree_out,
  output logic [WAY_COUNT_LOG2-1:0]      victim
);

  localparam int TN = (1 << WAY_COUNT_LOG2) - 1;

  logic [MAX_NODES-1:0]    t_ext, t_upd;
  logic [MAX_WAY_LOG2-1:0] v_ext;
  logic                    pad_unused;

  assign t_ext    = MAX_NODES'(tree_in);
  assign t_upd    = plru_touch(t_ext, MAX_WAY_LOG2'(way), WAY_COUNT_LOG2);
  assign v_ext    = plru_victim(t_ext, WAY_COUNT_LOG2);
  assign tree_out = t_upd[TN-1:0];
  assign victim   = v_ext[WAY_COUNT_LOG2-1:0];

  // The padding bits above the real tree never change; fold them away.
  assign pad_unused = ^{t_upd, v_ext};

endmodule

// File: rtl/common_pseudo_lru_tree_binwr_sets.sv
// Multi-set tree pseudo-LRU replacement engine with binary way interface.
//   clk, reset       : clock, synchronous active-high reset
//   wen/wset/waddr   : touch way waddr of set wset (way becomes MRU)
//   qen/qset         : victim query of set qset, answered next cycle
//   qvalid_mask      : per-way valid bits; any invalid way wins the query
//   qalloc           : with qen, mark the returned victim MRU
//   qresp_valid/addr : registered victim response; addr holds when idle
module common_pseudo_lru_tree_binwr_sets
  import common_pseudo_lru_tree_binwr_sets_pkg::*;
#(
  parameter int SET_COUNT_LOG2 = 2,
  parameter int WAY_COUNT_LOG2 = 2
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               wen,
  input  logic [(SET_COUNT_LOG2 > 0 ? SET_COUNT_LOG2 : 1)-1:0] wset,
  input  logic [WAY_COUNT_LOG2-1:0]                          waddr,
  input  logic                                               qen,
  input  logic [(SET_COUNT_LOG2 > 0 ? SET_COUNT_LOG2 : 1)-1:0] qset,
  input  logic [(1<<WAY_COUNT_LOG2)-1:0]                     qvalid_mask,
  input  logic                                               qalloc,
  output logic                                               qresp_valid,
  output logic [WAY_COUNT_LOG2-1:0]                          qresp_addr
);

  localparam int TW = 1 << WAY_COUNT_LOG2;
  localparam int TN = TW - 1;
  localparam int TS = 1 << SET_COUNT_LOG2;

  logic [TN-1:0] tree_q [TS];

  logic [TN-1:0]             q_tree, w_tree, w_next, a_base, a_next;
  logic [TN-1:0]             vict_tree_unused;
  logic [WAY_COUNT_LOG2-1:0] walk_victim, victim;
  logic [WAY_COUNT_LOG2-1:0] touch_vict_unused, alloc_vict_unused;
  logic [MAX_WAY_LOG2-1:0]   lz_ext;
  logic                      lz_unused;

  assign q_tree = tree_q[qset];
  assign w_tree = tree_q[wset];

  // Victim walk on the queried set; the update output is not needed here.
  common_pseudo_lru_tree_node_path #(.WAY_COUNT_LOG2(WAY_COUNT_LOG2)) u_vict (
    .tree_in (q_tree),
    .way     ('0),
    .tree_out(vict_tree_unused),
    .victim  (walk_victim)
  );

  // Ways beyond TW are padded as valid so they can never be picked.
  assign lz_ext    = lowest_zero(~MAX_WAYS'(~qvalid_mask));
  assign lz_unused = ^lz_ext;
  assign victim    = (&qvalid_mask) ? walk_victim : lz_ext[WAY_COUNT_LOG2-1:0];

  common_pseudo_lru_tree_node_path #(.WAY_COUNT_LOG2(WAY_COUNT_LOG2)) u_touch (
    .tree_in (w_tree),
    .way     (waddr),
    .tree_out(w_next),
    .victim  (touch_vict_unused)
  );

  // An alloc on the set being touched builds on the touched tree so the
  // alloc wins any shared path nodes.
  assign a_base = (wen && (wset == qset)) ? w_next : q_tree;

  common_pseudo_lru_tree_node_path #(.WAY_COUNT_LOG2(WAY_COUNT_LOG2)) u_alloc (
    .tree_in (a_base),
    .way     (victim),
    .tree_out(a_next),
    .victim  (alloc_vict_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < TS; s++) tree_q[s] <= '0;
      qresp_valid <= 1'b0;
      qresp_addr  <= '0;
    end else begin
      if (wen) tree_q[wset] <= w_next;
      // Later assignment wins when both hit the same set; a_next already
      // contains the touch in that case.
      if (qen && qalloc) tree_q[qset] <= a_next;
      qresp_valid <= qen;
      if (qen) qresp_addr <= victim;
    end
  end

endmodule

// File: tb/tb_common_pseudo_lru_tree_binwr_sets.sv
module tb_common_pseudo_lru_tree_binwr_sets;

  logic       clk = 1'b0;
  logic       reset, wen, qen, qalloc;
  logic [1:0] wset, waddr, qset;
  logic [3:0] qvalid_mask;
  logic       qresp_valid;
  logic [1:0] qresp_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  common_pseudo_lru_tree_binwr_sets #(.SET_COUNT_LOG2(2), .WAY_COUNT_LOG2(2)) dut (
    .clk(clk), .reset(reset), .wen(wen), .wset(wset), .waddr(waddr),
    .qen(qen), .qset(qset), .qvalid_mask(qvalid_mask), .qalloc(qalloc),
    .qresp_valid(qresp_valid), .qresp_addr(qresp_addr)
  );

  typedef struct {
    logic       rst;
    logic       wen;
    logic [1:0] wset;
    logic [1:0] waddr;
    logic       qen;
    logic [1:0] qset;
    logic [3:0] mask;
    logic       qalloc;
    logic       exp_valid;
    logic [1:0] exp_addr;
  } vec_t;

  // Reference: each set remembers, per tree level, which half holds the
  // older ways. root_old = 1 means ways 2/3 are older; pair_old[p] = 1 means
  // the odd way of pair p (ways 2p, 2p+1) is older.
  int root_old [4];
  int pair_old [4][2];

  function automatic vec_t mk(input logic r, input logic we, input int ws, input int wa,
                              input logic qe, input int qs, input logic [3:0] m,
                              input logic qa, input logic ev, input int ea);
    vec_t v;
    v.rst = r; v.wen = we; v.wset = ws[1:0]; v.waddr = wa[1:0];
    v.qen = qe; v.qset = qs[1:0]; v.mask = m; v.qalloc = qa;
    v.exp_valid = ev; v.exp_addr = ea[1:0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; wen = v.wen; wset = v.wset; waddr = v.waddr;
    qen = v.qen; qset = v.qset; qvalid_mask = v.mask; qalloc = v.qalloc;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_victim(input int s, input logic [3:0] m);
    if (m != 4'hF) begin
      for (int i = 0; i < 4; i++) if (!m[i]) return i;
    end
    if (root_old[s] == 0) return pair_old[s][0];
    return 2 + pair_old[s][1];
  endfunction

  task automatic model_touch(input int s, input int w);
    root_old[s]       = (w < 2) ? 1 : 0;
    pair_old[s][w/2]  = (w % 2 == 0) ? 1 : 0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      root_old[s] = 0; pair_old[s][0] = 0; pair_old[s][1] = 0;
    end
  endtask

  vec_t tbl [32];

  initial begin
    int exp_addr_hold;
    logic [3:0] all1;
    all1 = 4'hF;
    reset = 1'b1; wen = 0; wset = 0; waddr = 0; qen = 0; qset = 0;
    qvalid_mask = all1; qalloc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(qresp_valid), 0);
    check("reset_addr", int'(qresp_addr), 0);

    //               rst we ws wa qe qs mask  qa ev ea
    tbl[0]  = mk(0, 0, 0, 0, 1, 0, all1, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, all1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, all1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 0, all1, 0, 1, 2);
    tbl[4]  = mk(0, 1, 0, 2, 0, 0, all1, 0, 0, 2);
    tbl[5]  = mk(0, 0, 0, 0, 1, 0, all1, 0, 1, 1);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, all1, 0, 0, 1);
    tbl[7]  = mk(0, 1, 0, 1, 0, 0, all1, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 2, 0, 0, all1, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 3, 0, 0, all1, 0, 0, 1);
    tbl[10] = mk(0, 0, 0, 0, 1, 0, all1, 0, 1, 0);
    tbl[11] = mk(0, 1, 1, 0, 0, 0, all1, 0, 0, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 0, all1, 0, 0, 0);
    tbl[13] = mk(0, 1, 1, 0, 0, 0, all1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 1, 0, all1, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 1, 1, all1, 0, 1, 2);
    tbl[16] = mk(0, 1, 0, 2, 0, 0, all1, 0, 0, 2);
    tbl[17] = mk(0, 0, 0, 0, 1, 0, 4'b1011, 0, 1, 2);
    tbl[18] = mk(0, 0, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 1, 2, all1, 1, 1, 0);
    tbl[20] = mk(0, 0, 0, 0, 1, 2, all1, 1, 1, 2);
    tbl[21] = mk(0, 0, 0, 0, 1, 2, all1, 1, 1, 1);
    tbl[22] = mk(0, 0, 0, 0, 1, 2, all1, 1, 1, 3);
    tbl[23] = mk(0, 1, 3, 3, 1, 3, all1, 1, 1, 0);
    tbl[24] = mk(0, 0, 0, 0, 1, 3, all1, 0, 1, 2);
    tbl[25] = mk(1, 0, 0, 0, 1, 3, all1, 0, 0, 0);
    tbl[26] = mk(0, 0, 0, 0, 1, 0, all1, 0, 1, 0);
    tbl[27] = mk(0, 0, 0, 0, 1, 1, all1, 0, 1, 0);
    tbl[28] = mk(0, 0, 0, 0, 1, 2, all1, 0, 1, 0);
    tbl[29] = mk(0, 0, 0, 0, 1, 3, all1, 0, 1, 0);
    // Touch and plain query of the same set: response sees pre-touch state.
    tbl[30] = mk(0, 1, 0, 0, 1, 0, all1, 0, 1, 0);
    tbl[31] = mk(0, 0, 0, 0, 1, 0, all1, 0, 1, 2);

    for (int i = 0; i < 32; i++) begin
      drive(tbl[i]);
      check($sformatf("vec%0d_valid", i), int'(qresp_valid), int'(tbl[i].exp_valid));
      check($sformatf("vec%0d_addr", i), int'(qresp_addr), int'(tbl[i].exp_addr));
    end

    // Randomized traffic against the reference model, from a clean reset.
    drive(mk(1, 0, 0, 0, 0, 0, all1, 0, 0, 0));
    check("rand_reset_valid", int'(qresp_valid), 0);
    model_reset();
    exp_addr_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      int   vict;
      v.rst    = 1'b0;
      v.wen    = 1'($urandom_range(0, 1));
      v.wset   = 2'($urandom_range(0, 3));
      v.waddr  = 2'($urandom_range(0, 3));
      v.qen    = 1'($urandom_range(0, 3) != 0);
      v.qset   = ($urandom_range(0, 1) != 0) ? v.wset : 2'($urandom_range(0, 3));
      v.mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : all1;
      v.qalloc = 1'($urandom_range(0, 1));
      vict = model_victim(int'(v.qset), v.mask);
      if (v.qen) exp_addr_hold = vict;
      drive(v);
      check($sformatf("rand%0d_valid", c), int'(qresp_valid), int'(v.qen));
      check($sformatf("rand%0d_addr", c), int'(qresp_addr), exp_addr_hold);
      if (v.wen) model_touch(int'(v.wset), int'(v.waddr));
      if (v.qen && v.qalloc) model_touch(int'(v.qset), vict);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
